instr_encoder: RTL and testbench

- Packs decoded RISC-V instruction fields plus a 32-bit immediate into a 32-bit instruction word.
- This is the inverse of the immediate extender, and it uses the same 2-bit immediate-format code.
- Used by the program loader / self-test generator to stream encoded words into instruction memory.
- Two-stage valid/ready pipeline with per-word immediate range checking, an instruction-memory write address, and a word count.

---
 rtl/instr_encoder.sv | 234 +++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Packs decoded RISC-V fields plus a 32-bit immediate into a 32-bit
//   instruction word. This is the inverse of the immediate extender and uses
//   the same 2-bit format code (00 I, 01 S, 10 B, 11 R). Words stream out
//   with an instruction-memory write address, an out-of-range flag, a
//   sticky first-error capture and a saturating word count.
//
//   Pipeline: stage 1 registers the raw fields; stage 2 registers the packed
//   word and its range flag. One word per cycle, and a word accepted at
//   edge N is presented after edge N+1.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), async active-low reset
//   clr_i              sync clear of address, count and error capture
//   in_valid_i/in_ready_o     input handshake
//   immsrc_i           immediate format code
//   opcode_i, rd_i, funct3_i, rs1_i, rs2_i, funct7_i, imm_i   input fields
//   out_valid_o/out_ready_i   output handshake
//   instr_o, addr_o, err_o    presented word, its address, range flag
//   err_sticky_o, err_addr_o  first erroneous word seen, and its address
//   count_o            words handshaken, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            immsrc_i,
  input  logic [6:0]            opcode_i,
  input  logic [4:0]            rd_i,
  input  logic [2:0]            funct3_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [6:0]            funct7_i,
  input  logic [31:0]           imm_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  err_o,
  output logic                  err_sticky_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [15:0]           count_o
);

  localparam logic [31:0]           BASE_WORD    = 32'(BASE_ADDR);
  // Instruction memory is word addressed in bytes, so the base is forced
  // onto a 4-byte boundary.
  localparam logic [ADDR_WIDTH-1:0] BASE_ALIGNED = {BASE_WORD[ADDR_WIDTH-1:2], 2'b00};
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP    = ADDR_WIDTH'(4);

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;
  localparam logic [1:0] FMT_R = 2'b11;

  // Stage 1 field registers
  logic        r_s1_valid;
  logic [1:0]  r_s1_immsrc;
  logic [6:0]  r_s1_opcode;
  logic [4:0]  r_s1_rd;
  logic [2:0]  r_s1_funct3;
  logic [4:0]  r_s1_rs1;
  logic [4:0]  r_s1_rs2;
  logic [6:0]  r_s1_funct7;
  logic [31:0] r_s1_imm;

  // Stage 2 word registers
  logic        r_s2_valid;
  logic [31:0] r_s2_instr;
  logic        r_s2_err;

  // Write-side bookkeeping
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_count;
  logic                  r_err_sticky;
  logic [ADDR_WIDTH-1:0] r_err_addr;

  // Low throughout reset and set by the first edge after release, so that
  // in_ready_o reads 0 while the block is held in reset.
  logic r_run;

  logic        w_s2_free;
  logic        w_s1_load;
  logic        w_in_hs;
  logic        w_out_hs;
  logic [31:0] w_packed;
  logic        w_range_err;
  logic        w_imm12_ok;
  logic        w_imm13_ok;

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  assign w_s2_free = !r_s2_valid | out_ready_i;
  assign w_s1_load = r_run & (!r_s1_valid | w_s2_free);
  assign w_in_hs   = in_valid_i & w_s1_load;
  assign w_out_hs  = r_s2_valid & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: capture input fields
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid  <= 1'b0;
      r_s1_immsrc <= '0;
      r_s1_opcode <= '0;
      r_s1_rd     <= '0;
      r_s1_funct3 <= '0;
      r_s1_rs1    <= '0;
      r_s1_rs2    <= '0;
      r_s1_funct7 <= '0;
      r_s1_imm    <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid_i;
      if (w_in_hs) begin
        r_s1_immsrc <= immsrc_i;
        r_s1_opcode <= opcode_i;
        r_s1_rd     <= rd_i;
        r_s1_funct3 <= funct3_i;
        r_s1_rs1    <= rs1_i;
        r_s1_rs2    <= rs2_i;
        r_s1_funct7 <= funct7_i;
        r_s1_imm    <= imm_i;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Packing. Fields a format does not consume pass through from the inputs,
  // so the R layout is the starting point and each format overwrites only
  // its immediate slices.
  // -------------------------------------------------------------------------
  always_comb begin
    w_packed = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
    unique case (r_s1_immsrc)
      FMT_I: w_packed = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
      FMT_S: w_packed = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                         r_s1_imm[4:0], r_s1_opcode};
      FMT_B: w_packed = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                         r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
      FMT_R: w_packed = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
      default: w_packed = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
    endcase
  end

  // An immediate fits in N signed bits when every bit above N-1 equals the
  // sign bit, i.e. bits [31:N-1] are all zeros or all ones.
  assign w_imm12_ok = (&r_s1_imm[31:11]) | ~(|r_s1_imm[31:11]);
  assign w_imm13_ok = (&r_s1_imm[31:12]) | ~(|r_s1_imm[31:12]);

  always_comb begin
    w_range_err = 1'b0;
    unique case (r_s1_immsrc)
      FMT_I, FMT_S: w_range_err = !w_imm12_ok;
      // Branch offsets are halfword aligned; an odd offset would silently
      // lose imm[0] in the encoding.
      FMT_B:        w_range_err = !w_imm13_ok | r_s1_imm[0];
      FMT_R:        w_range_err = 1'b0;
      default:      w_range_err = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage 2: packed word and range flag. Held while stalled.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr <= w_packed;
        r_s2_err   <= w_range_err;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Address, count and first-error capture. A clear on the same edge as a
  // handshake wins: the word went out at the old address but is not counted
  // or captured.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr       <= BASE_ALIGNED;
      r_count      <= '0;
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
    end else if (clr_i) begin
      r_addr       <= BASE_ALIGNED;
      r_count      <= '0;
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
    end else if (w_out_hs) begin
      r_addr <= r_addr + ADDR_STEP;
      if (r_count != 16'hFFFF) begin
        r_count <= r_count + 16'd1;
      end
      if (r_s2_err && !r_err_sticky) begin
        r_err_sticky <= 1'b1;
        r_err_addr   <= r_addr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready_o   = w_s1_load;
  assign out_valid_o  = r_s2_valid;
  assign instr_o      = r_s2_instr;
  assign err_o        = r_s2_err;
  assign addr_o       = r_addr;
  assign count_o      = r_count;
  assign err_sticky_o = r_err_sticky;
  assign err_addr_o   = r_err_addr;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Scoreboard bench for instr_encoder. The driver computes the expected
//   word for whatever it presents; a negedge monitor queues it on the input
//   handshake and compares it whenever the encoder presents a word.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int AW = 8;
  localparam logic [AW-1:0] BASE = 8'h00;

  typedef struct {
    logic [31:0] w;
    logic        e;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    immsrc;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [2:0]    funct3;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   instr;
  logic [AW-1:0] addr;
  logic          err;
  logic          err_sticky;
  logic [AW-1:0] err_addr;
  logic [15:0]   count;

  int checks = 0;
  int errors = 0;

  exp_t q[$];
  exp_t drv_exp;

  // reference bookkeeping state
  int          m_addr   = 0;
  int          m_cnt    = 0;
  logic        m_sticky = 1'b0;
  int          m_eaddr  = 0;

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (clr),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .immsrc_i     (immsrc),
    .opcode_i     (opcode),
    .rd_i         (rd),
    .funct3_i     (funct3),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .funct7_i     (funct7),
    .imm_i        (imm),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .instr_o      (instr),
    .addr_o       (addr),
    .err_o        (err),
    .err_sticky_o (err_sticky),
    .err_addr_o   (err_addr),
    .count_o      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding computed from field bit positions with plain integer arithmetic.
  function automatic exp_t ref_enc(input int fmt, input int op, input int rdv, input int f3,
                                   input int r1, input int r2, input int f7, input int immv);
    exp_t r;
    int unsigned u;
    int unsigned w;
    u = immv;
    w = op + (f3 << 12) + (r1 << 15);
    r.e = 1'b0;
    case (fmt)
      0: begin
        w = w + (rdv << 7) + ((u % 4096) << 20);
        r.e = (immv < -2048) || (immv > 2047);
      end
      1: begin
        w = w + ((u % 32) << 7) + (r2 << 20) + (((u / 32) % 128) << 25);
        r.e = (immv < -2048) || (immv > 2047);
      end
      2: begin
        w = w + (((u / 2048) % 2) << 7) + (((u / 2) % 16) << 8) + (r2 << 20)
              + (((u / 32) % 64) << 25) + (((u / 4096) % 2) << 31);
        r.e = (immv < -4096) || (immv > 4094) || ((u % 2) != 0);
      end
      default: begin
        w = w + (rdv << 7) + (r2 << 20) + (f7 << 25);
      end
    endcase
    r.w = w;
    return r;
  endfunction

  task automatic set_fields(input int fmt, input int op, input int rdv, input int f3,
                            input int r1, input int r2, input int f7, input int immv);
    immsrc  = 2'(fmt);
    opcode  = 7'(op);
    rd      = 5'(rdv);
    funct3  = 3'(f3);
    rs1     = 5'(r1);
    rs2     = 5'(r2);
    funct7  = 7'(f7);
    imm     = immv;
    drv_exp = ref_enc(fmt, op, rdv, f3, r1, r2, f7, immv);
  endtask

  function automatic int pick_imm();
    case ($urandom_range(0, 9))
      0: return 2047;
      1: return -2048;
      2: return 2048;
      3: return -2049;
      4: return 4094;
      5: return -4096;
      6: return 4095;
      7: return 4096;
      8: return int'($urandom);
      default: return int'($urandom_range(0, 8191)) - 4096;
    endcase
  endfunction

  task automatic set_random_word();
    set_fields(int'($urandom_range(0, 3)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 127)), pick_imm());
  endtask

  // Present a word with a fixed expectation and wait (bounded) for accept.
  task automatic send(input int fmt, input int op, input int rdv, input int f3, input int r1,
                      input int r2, input int f7, input int immv, input logic [31:0] ew,
                      input logic ee);
    logic acc;
    acc = 1'b0;
    set_fields(fmt, op, rdv, f3, r1, r2, f7, immv);
    drv_exp.w = ew;
    drv_exp.e = ee;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accept", acc, 1'b1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", q.size() + int'(out_valid), 0);
  endtask

  task automatic random_phase(input int cycles, input int clr_den);
    for (int i = 0; i < cycles; i++) begin
      set_random_word();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      clr       = (clr_den > 0) && ($urandom_range(1, clr_den) == 1);
      @(posedge clk);
      #1;
    end
    clr = 1'b0;
  endtask

  // Scoreboard monitor: samples at the falling edge, between driver updates.
  always @(negedge clk) begin
    exp_t e;
    logic hs;
    logic hs_err;
    hs     = 1'b0;
    hs_err = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_addr   = int'(BASE);
      m_cnt    = 0;
      m_sticky = 1'b0;
      m_eaddr  = 0;
    end else begin
      check("addr", addr, m_addr);
      check("count", count, m_cnt);
      check("err_sticky", err_sticky, m_sticky);
      check("err_addr", err_addr, m_eaddr);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_word", out_valid, 1'b0);
        end else begin
          e = q[0];
          check("instr", instr, e.w);
          check("err", err, e.e);
          if (out_ready) begin
            void'(q.pop_front());
            hs     = 1'b1;
            hs_err = e.e;
          end
        end
      end
      if (clr) begin
        m_addr   = int'(BASE);
        m_cnt    = 0;
        m_sticky = 1'b0;
        m_eaddr  = 0;
      end else if (hs) begin
        if (hs_err && !m_sticky) begin
          m_sticky = 1'b1;
          m_eaddr  = m_addr;
        end
        m_addr = (m_addr + 4) % 256;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      if (in_valid && in_ready) q.push_back(drv_exp);
    end
  end

  initial begin
    int   n_acc;
    logic acc;
    logic [31:0]   held_instr;
    logic [AW-1:0] held_addr;

    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_fields(0, 0, 0, 0, 0, 0, 0, 0);

    // reset state
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_addr", addr, BASE);
    check("rst_err", err, 1'b0);
    check("rst_sticky", err_sticky, 1'b0);
    check("rst_err_addr", err_addr, 0);
    check("rst_count", count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", in_ready, 1'b1);

    // four back-to-back directed words, with latency check on the first
    send(0, 'h13, 1, 0, 0, 0, 0, -1, 32'hFFF00093, 1'b0);
    check("latency_edge_n", out_valid, 1'b0);
    send(1, 'h23, 0, 2, 1, 2, 0, 8, 32'h0020A423, 1'b0);
    check("latency_edge_n1", out_valid, 1'b1);
    send(2, 'h63, 0, 0, 0, 0, 0, -4, 32'hFE000EE3, 1'b0);
    send(3, 'h33, 3, 0, 1, 2, 0, 0, 32'h002081B3, 1'b0);
    drain();
    check("count_after_4", count, 4);
    check("addr_after_4", addr, 8'h10);

    // range errors: first captured, later one ignored
    send(0, 'h13, 0, 0, 0, 0, 0, 2048, 32'h80000013, 1'b1);
    send(2, 'h63, 0, 0, 0, 0, 0, 3, 32'h00000163, 1'b1);
    drain();
    check("sticky_set", err_sticky, 1'b1);
    check("err_addr_first", err_addr, 8'h10);
    check("count_after_err", count, 6);

    // backpressure: consumer stalls, producer keeps offering
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_random_word();
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        set_random_word();
      end
    end
    check("bp_accepted", n_acc, 2);
    check("bp_in_ready", in_ready, 1'b0);
    held_instr = instr;
    held_addr  = addr;
    repeat (2) @(posedge clk);
    #1;
    check("bp_instr_stable", instr, held_instr);
    check("bp_addr_stable", addr, held_addr);
    check("bp_out_valid", out_valid, 1'b1);
    drain();
    check("count_after_bp", count, 8);

    // clear coinciding with an output handshake
    send(3, 'h33, 3, 0, 1, 2, 0, 0, 32'h002081B3, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("clr_word_present", out_valid, 1'b1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_addr", addr, BASE);
    check("clr_count", count, 0);
    check("clr_sticky", err_sticky, 1'b0);
    check("clr_err_addr", err_addr, 0);

    // long random stream without clears: address wraps several times
    random_phase(700, 0);

    // asynchronous reset mid-stream
    set_random_word();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_count", count, 0);
    check("async_in_ready", in_ready, 1'b0);
    check("async_addr", addr, BASE);
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_pulse", in_ready, 1'b1);

    // random stream with occasional clears
    random_phase(600, 60);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
